uart_show_tx: RTL and testbench
===============================

UART_SHOW_TX -- requirements
Module: uart_show_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (115200 baud at 100 MHz); legal range 2..65535.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-004 SHALL have port start, input, 1, request to transmit the current tx_show/show_len, sampled on posedge clk.
REQ-005 SHALL have port tx_show, input, 128, message bytes: byte k = tx_show[127-8k -: 8].
REQ-006 SHALL have port show_len, input, 5, number of bytes to send.
REQ-007 SHALL have port tx, output, 1, UART serial line, idle high.
REQ-008 SHALL have port busy, output, 1, high while a message is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when a message completes.

Function
REQ-010 SHALL implement states IDLE, START, DATA, STOP.
REQ-011 In IDLE, start=1 SHALL latch tx_show and show_len into internal registers, set byte index to 0, and enter START on the next edge; busy rises on that same edge.
REQ-012 Latched length SHALL be clamped: show_len 17..31 is treated as 16.
REQ-013 Latched length 0 SHALL skip transmission: stay in IDLE, busy stays 0, done pulses exactly one cycle after the start edge, tx stays 1.
REQ-014 START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-015 DATA SHALL send the 8 bits of the current byte LSB first, each held for exactly CLKS_PER_BIT cycles, then enter STOP.
REQ-016 STOP SHALL drive tx=1 for exactly CLKS_PER_BIT cycles.
REQ-017 At the end of STOP, if more bytes remain, the block SHALL increment the byte index and enter START with no idle gap.
REQ-018 At the end of STOP for the last byte, the block SHALL enter IDLE, drop busy, and pulse done for one cycle on the same edge.
REQ-019 One frame SHALL last exactly 10*CLKS_PER_BIT cycles, and a message of N bytes SHALL keep busy high for exactly N*10*CLKS_PER_BIT cycles.
REQ-020 start SHALL be ignored while busy=1; changes to tx_show and show_len while busy SHALL NOT affect the message in flight.
REQ-021 start asserted in the same cycle that done pulses SHALL begin a new message, so busy goes 0 for one cycle and then returns to 1.
REQ-022 The bit-period counter SHALL be width ceil(log2(CLKS_PER_BIT)) and SHALL never wrap mid-bit; it reloads at every bit boundary.
REQ-023 tx SHALL be a registered output (glitch-free).

Reset
REQ-024 While reset=0, the block SHALL force state=IDLE, tx=1, busy=0, done=0, and clear all counters and indices, asynchronously.
REQ-025 Reset asserted mid-frame SHALL abort the message immediately: tx returns to 1 with no stop bit owed and no done pulse.
REQ-026 After reset release, the block SHALL accept start on the first posedge.

Verification (CLKS_PER_BIT=4)
REQ-027 Single byte: tx_show[127:120]=8'h55, show_len=1, pulse start -> tx holds 0 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles; busy high for 40 cycles; one done pulse.
REQ-028 Multi-byte: tx_show=128'h4142_43.. (first three bytes "ABC"), show_len=3 -> frames 0x41, 0x42, 0x43 back-to-back; busy high for 120 cycles; one done pulse.
REQ-029 Length edges: show_len=0 -> done one cycle after start, tx never low. show_len=31 -> exactly 16 frames (640 cycles).
REQ-030 Start while busy: re-pulse start and change tx_show mid-frame of the REQ-027 case -> output is identical to REQ-027, and exactly one done pulse.
REQ-031 Reset mid-operation: assert reset during bit 3 of the first byte -> tx=1 and busy=0 immediately with no done pulse; after release, a new start transmits correctly.
REQ-032 Back-to-back messages: hold start high across a done pulse -> busy is low for exactly one cycle, and the second message starts with a start bit.

Source files
------------

// File: rtl/uart_show_tx.sv
// UART transmitter for a short message of up to 16 bytes held in a 128-bit word.
// Byte 0 is the most significant byte. Frames are 8N1, LSB first, and are sent back-to-back.
module uart_show_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] tx_show,
  input  logic [4:0]   show_len,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [3:0]     byte_idx_q, byte_idx_d;
  logic [4:0]     len_q, len_d;
  logic [127:0]   data_q, data_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           bit_end;
  logic           last_byte;
  logic [4:0]     clamped_len;

  assign bit_end     = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign last_byte   = (({1'b0, byte_idx_q} + 5'd1) == len_q);
  assign clamped_len = (show_len > 5'd16) ? 5'd16 : show_len;

  // Bit b of byte k sits at data_q[8*(15-k) + b], i.e. index {~k, b}.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    len_d      = len_q;
    data_d     = data_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          data_d     = tx_show;
          len_d      = clamped_len;
          byte_idx_d = 4'd0;
          bit_idx_d  = 3'd0;
          cnt_d      = '0;
          if (clamped_len == 5'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = START;
            busy_d  = 1'b1;
            tx_d    = 1'b0;
          end
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = data_q[{~byte_idx_q, 3'd0}];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = data_q[{~byte_idx_q, bit_idx_d}];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (last_byte) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d    = START;
            byte_idx_d = byte_idx_q + 4'd1;
            bit_idx_d  = 3'd0;
            tx_d       = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 4'd0;
      len_q      <= 5'd0;
      data_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      len_q      <= len_d;
      data_q     <= data_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_show_tx.sv
// Directed bench for uart_show_tx: a frame receiver checks every 40-cycle tx waveform and
// every busy run length against queues filled when each message is started.
module tb_uart_show_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] tx_show;
  logic [4:0]   show_len;
  logic         tx;
  logic         busy;
  logic         done;

  int n_vec    = 0;
  int n_err    = 0;
  int done_cnt = 0;

  logic [7:0] exp_q[$];
  int         busy_q[$];

  logic             rx_active = 1'b0;
  int               rx_cyc    = 0;
  logic [FRAME-1:0] rx_wave;
  logic [FRAME-1:0] exp_wave;
  logic             prev_busy = 1'b0;
  int               busy_run  = 0;

  uart_show_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .tx_show  (tx_show),
    .show_len (show_len),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ideal line waveform of one 8N1 frame, one entry per clock.
  function automatic logic [FRAME-1:0] frame_wave(input logic [7:0] b);
    logic [FRAME-1:0] w;
    int slot;
    for (int i = 0; i < FRAME; i++) begin
      slot = i / CPB;
      if (slot == 0)      w[i] = 1'b0;
      else if (slot <= 8) w[i] = b[slot-1];
      else                w[i] = 1'b1;
    end
    return w;
  endfunction

  // Monitor: samples outputs on the falling edge, far from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      rx_active = 1'b0;
      rx_cyc    = 0;
      prev_busy = 1'b0;
      busy_run  = 0;
    end else begin
      if (rx_active) begin
        rx_wave[rx_cyc] = tx;
        rx_cyc++;
        if (rx_cyc == FRAME) begin
          chk("frame_wave", 64'(rx_wave), 64'(exp_wave));
          rx_active = 1'b0;
        end
      end else if (tx === 1'b0) begin
        chk("frame_expected", 64'(exp_q.size() > 0), 64'd1);
        exp_wave   = frame_wave((exp_q.size() > 0) ? exp_q.pop_front() : 8'h00);
        rx_wave    = '0;
        rx_wave[0] = tx;
        rx_cyc     = 1;
        rx_active  = 1'b1;
      end

      if (busy) busy_run++;
      if (prev_busy && !busy) begin
        chk("done_at_busy_fall", 64'(done), 64'd1);
        chk("busy_len", 64'(busy_run), 64'((busy_q.size() > 0) ? busy_q.pop_front() : 0));
        busy_run = 0;
      end
      if (done) done_cnt++;
      prev_busy = busy;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] data, input logic [4:0] len, input bit release_rst);
    int eff;
    eff = (len > 5'd16) ? 16 : int'(len);
    step();
    if (release_rst) reset = 1'b1;
    tx_show  = data;
    show_len = len;
    start    = 1'b1;
    for (int k = 0; k < eff; k++) exp_q.push_back(data[127-8*k -: 8]);
    if (eff > 0) busy_q.push_back(eff * FRAME);
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while ((busy || rx_active) && n < 2000);
    chk(tag, 64'(busy | rx_active), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int n;
    logic [127:0] rnd;

    reset    = 1'b0;
    start    = 1'b0;
    tx_show  = '0;
    show_len = 5'd0;
    repeat (2) step();
    chk("rst_tx", 64'(tx), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    // Single byte 0x55, started on the first edge after reset release
    d0 = done_cnt;
    send({8'h55, 120'h0}, 5'd1, 1'b1);
    chk("single_busy_rise", 64'(busy), 64'd1);
    chk("single_start_bit", 64'(tx), 64'd0);
    wait_idle("single_idle");
    chk("single_done_cnt", 64'(done_cnt - d0), 64'd1);

    // Three bytes "ABC"
    d0 = done_cnt;
    send({24'h414243, 104'h0}, 5'd3, 1'b0);
    wait_idle("abc_idle");
    chk("abc_done_cnt", 64'(done_cnt - d0), 64'd1);

    // Zero length: done only, no busy, line stays high
    d0 = done_cnt;
    send({8'h00, 120'h0}, 5'd0, 1'b0);
    chk("len0_done", 64'(done), 64'd1);
    chk("len0_busy", 64'(busy), 64'd0);
    chk("len0_tx", 64'(tx), 64'd1);
    step();
    chk("len0_done_drop", 64'(done), 64'd0);
    chk("len0_done_cnt", 64'(done_cnt - d0), 64'd1);

    // Length 31 clamps to 16 frames
    d0  = done_cnt;
    rnd = {$urandom, $urandom, $urandom, $urandom};
    send(rnd, 5'd31, 1'b0);
    wait_idle("len31_idle");
    chk("len31_done_cnt", 64'(done_cnt - d0), 64'd1);

    // Start and new data while busy are ignored
    d0 = done_cnt;
    send({8'h55, 120'h0}, 5'd1, 1'b0);
    repeat (11) step();
    tx_show  = '1;
    show_len = 5'd5;
    start    = 1'b1;
    step();
    start    = 1'b0;
    tx_show  = '0;
    wait_idle("busy_start_idle");
    repeat (3) step();
    chk("busy_start_no_restart", 64'(busy), 64'd0);
    chk("busy_start_done_cnt", 64'(done_cnt - d0), 64'd1);

    // Reset during bit 3 of the first byte aborts without done
    send({8'hA5, 8'h3C, 112'h0}, 5'd2, 1'b0);
    repeat (17) step();
    d0    = done_cnt;
    reset = 1'b0;
    #1;
    chk("abort_tx", 64'(tx), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    exp_q.delete();
    busy_q.delete();
    repeat (2) step();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    send({8'h3C, 120'h0}, 5'd1, 1'b1);
    chk("after_rst_busy", 64'(busy), 64'd1);
    wait_idle("after_rst_idle");
    chk("after_rst_done_cnt", 64'(done_cnt - d0), 64'd1);

    // Start held high across done: one-cycle busy gap, then a new start bit
    d0 = done_cnt;
    step();
    tx_show  = {8'h0F, 120'h0};
    show_len = 5'd1;
    start    = 1'b1;
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'hF0);
    busy_q.push_back(FRAME);
    busy_q.push_back(FRAME);
    step();
    tx_show = {8'hF0, 120'h0};
    n = 0;
    do begin
      step();
      n++;
    end while (!done && n < 200);
    chk("b2b_done_seen", 64'(done), 64'd1);
    chk("b2b_busy_gap", 64'(busy), 64'd0);
    step();
    chk("b2b_busy_back", 64'(busy), 64'd1);
    chk("b2b_start_bit", 64'(tx), 64'd0);
    start = 1'b0;
    wait_idle("b2b_idle");
    chk("b2b_done_cnt", 64'(done_cnt - d0), 64'd2);

    chk("frames_all_seen", 64'(exp_q.size()), 64'd0);
    chk("busy_runs_all_seen", 64'(busy_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
